// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, NOP constant, and
// the packed control bundle driven by the hazard unit.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } state_e;

  // addi x0, x0, 0 -- the instruction a flushed pipeline register carries
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_stall;
    logic exmem_stall;
    logic ifid_flush;
    logic idex_flush;
    logic wb_bubble;
  } ctrl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        ex_memread;
  logic [4:0]  ex_rd;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_stall;
  logic        ifid_stall;
  logic        idex_stall;
  logic        exmem_stall;
  logic        ifid_flush;
  logic        idex_flush;
  logic        wb_bubble;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] flush_events;
  state_e      dbg_state;

  // Datapath side: supplies pipeline status, consumes hazard control.
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush,
           idex_flush, wb_bubble, mem_timeout, stall_cycles, flush_events,
           dbg_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memread, ex_rd,
           ex_branch_taken, mem_req, mem_ready,
    output pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush,
           idex_flush, wb_bubble, mem_timeout, stall_cycles, flush_events,
           dbg_state
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush, data-memory
// wait freeze with timeout, plus stall/flush event counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT - 1);

  state_e     state_q;
  logic [7:0] wait_cnt_q;
  logic       timeout_q;

  logic   mem_wait;
  logic   load_use;
  state_e eff_state;
  ctrl_t  ctrl;

  assign mem_wait = hz.mem_req & ~hz.mem_ready;
  assign load_use = hz.ex_memread & (hz.ex_rd != 5'd0) &
                    ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                     (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));

  // While reset is asserted the controller already behaves as if in RUN.
  assign eff_state = rst ? state_q : ST_RUN;

  always_comb begin
    ctrl = '0;
    if (eff_state == ST_TIMEOUT || mem_wait) begin
      ctrl.pc_stall    = 1'b1;
      ctrl.ifid_stall  = 1'b1;
      ctrl.idex_stall  = 1'b1;
      ctrl.exmem_stall = 1'b1;
      ctrl.wb_bubble   = 1'b1;
    end else if (hz.ex_branch_taken) begin
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
    end else if (load_use) begin
      ctrl.pc_stall    = 1'b1;
      ctrl.ifid_stall  = 1'b1;
      ctrl.idex_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_wait) begin
            state_q    <= ST_MEM_WAIT;
            wait_cnt_q <= 8'd1;
          end
        end
        ST_MEM_WAIT: begin
          // A completing access on the limit cycle is not a timeout.
          if (!mem_wait) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
          end else if (wait_cnt_q == WAIT_LIMIT) begin
            state_q   <= ST_TIMEOUT;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        ST_TIMEOUT: begin
          state_q <= ST_TIMEOUT;
        end
        default: begin
          state_q    <= ST_RUN;
          wait_cnt_q <= 8'd0;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(32)) u_stall_cnt (
    .clk     (clk),
    .clr_i   (~rst),
    .inc_i   (ctrl.pc_stall),
    .count_o (hz.stall_cycles)
  );

  sat_counter #(.WIDTH(16)) u_flush_cnt (
    .clk     (clk),
    .clr_i   (~rst),
    .inc_i   (ctrl.ifid_flush),
    .count_o (hz.flush_events)
  );

  assign hz.pc_stall    = ctrl.pc_stall;
  assign hz.ifid_stall  = ctrl.ifid_stall;
  assign hz.idex_stall  = ctrl.idex_stall;
  assign hz.exmem_stall = ctrl.exmem_stall;
  assign hz.ifid_flush  = ctrl.ifid_flush;
  assign hz.idex_flush  = ctrl.idex_flush;
  assign hz.wb_bubble   = ctrl.wb_bubble;
  assign hz.mem_timeout = timeout_q;
  assign hz.dbg_state   = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MAX_WAIT=4): hazards, waits, timeout,
// reset override and counter saturation.
module tb_hazard_ctrl;

  localparam logic [6:0] C_NONE   = 7'b000_0000;
  localparam logic [6:0] C_LOADU  = 7'b110_0010;
  localparam logic [6:0] C_BRANCH = 7'b000_0110;
  localparam logic [6:0] C_FREEZE = 7'b111_1001;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  hazard_ctrl_if hz_if ();

  hazard_ctrl #(.MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz_if.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz_if.id_rs1          = 5'd0;
    hz_if.id_rs2          = 5'd0;
    hz_if.id_use_rs1      = 1'b0;
    hz_if.id_use_rs2      = 1'b0;
    hz_if.ex_memread      = 1'b0;
    hz_if.ex_rd           = 5'd0;
    hz_if.ex_branch_taken = 1'b0;
    hz_if.mem_req         = 1'b0;
    hz_if.mem_ready       = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic [6:0] exp);
    #1;
    chk(tag, {25'd0, hz_if.pc_stall, hz_if.ifid_stall, hz_if.idex_stall,
              hz_if.exmem_stall, hz_if.ifid_flush, hz_if.idex_flush,
              hz_if.wb_bubble}, {25'd0, exp});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    clear_inputs();
    tick();
    tick();
    chk_ctrl("ctrl_in_reset", C_NONE);
    rst = 1'b1;
    #1;
    chk("reset_state", 32'(hz_if.dbg_state), 32'd0);
    chk("reset_timeout", 32'(hz_if.mem_timeout), 32'd0);
    chk("reset_stall_cnt", hz_if.stall_cycles, 32'd0);
    chk("reset_flush_cnt", 32'(hz_if.flush_events), 32'd0);

    // load x5 in EX, ID reads rs2=x5
    hz_if.ex_memread = 1'b1; hz_if.ex_rd = 5'd5;
    hz_if.id_rs1 = 5'd3; hz_if.id_use_rs1 = 1'b1;
    hz_if.id_rs2 = 5'd5; hz_if.id_use_rs2 = 1'b1;
    chk_ctrl("load_use_rs2", C_LOADU);
    tick();
    clear_inputs();
    chk_ctrl("after_load_use", C_NONE);
    chk("stall_cnt_1", hz_if.stall_cycles, 32'd1);

    // load x0 never interlocks
    hz_if.ex_memread = 1'b1; hz_if.ex_rd = 5'd0;
    hz_if.id_rs1 = 5'd0; hz_if.id_use_rs1 = 1'b1;
    chk_ctrl("load_x0", C_NONE);
    // matching register but operand unused
    hz_if.ex_rd = 5'd7; hz_if.id_rs1 = 5'd7; hz_if.id_use_rs1 = 1'b0;
    chk_ctrl("rs1_not_used", C_NONE);
    hz_if.id_use_rs1 = 1'b1;
    chk_ctrl("load_use_rs1", C_LOADU);
    // branch outranks load-use
    hz_if.ex_branch_taken = 1'b1;
    chk_ctrl("branch_over_load_use", C_BRANCH);
    tick();
    clear_inputs();
    chk("flush_cnt_1", 32'(hz_if.flush_events), 32'd1);
    chk("stall_cnt_still_1", hz_if.stall_cycles, 32'd1);

    // 3-cycle memory wait with a pending branch held through it
    hz_if.mem_req = 1'b1; hz_if.mem_ready = 1'b0; hz_if.ex_branch_taken = 1'b1;
    chk_ctrl("wait1_freeze", C_FREEZE);
    tick();
    chk("wait1_state", 32'(hz_if.dbg_state), 32'd1);
    chk_ctrl("wait2_freeze", C_FREEZE);
    tick();
    chk_ctrl("wait3_freeze", C_FREEZE);
    tick();
    hz_if.mem_ready = 1'b1;
    chk_ctrl("wait_done_branch", C_BRANCH);
    tick();
    clear_inputs();
    chk("wait_back_run", 32'(hz_if.dbg_state), 32'd0);
    chk("stall_cnt_4", hz_if.stall_cycles, 32'd4);
    chk("flush_cnt_2", 32'(hz_if.flush_events), 32'd2);

    // ready arrives on the limit cycle: no timeout
    hz_if.mem_req = 1'b1;
    repeat (3) tick();
    chk("limit_state", 32'(hz_if.dbg_state), 32'd1);
    hz_if.mem_ready = 1'b1;
    chk_ctrl("limit_ready", C_NONE);
    tick();
    clear_inputs();
    chk("limit_no_timeout", 32'(hz_if.mem_timeout), 32'd0);
    chk("limit_run", 32'(hz_if.dbg_state), 32'd0);
    chk("stall_cnt_7", hz_if.stall_cycles, 32'd7);

    // timeout after 4 consecutive wait cycles
    hz_if.mem_req = 1'b1;
    repeat (3) tick();
    chk("pre_timeout", 32'(hz_if.mem_timeout), 32'd0);
    tick();
    chk("timeout_flag", 32'(hz_if.mem_timeout), 32'd1);
    chk("timeout_state", 32'(hz_if.dbg_state), 32'd2);
    chk("stall_cnt_11", hz_if.stall_cycles, 32'd11);
    clear_inputs();
    hz_if.ex_branch_taken = 1'b1;
    chk_ctrl("timeout_freeze", C_FREEZE);
    tick();
    chk("timeout_sticky", 32'(hz_if.mem_timeout), 32'd1);
    chk("stall_cnt_12", hz_if.stall_cycles, 32'd12);
    rst = 1'b0;
    chk_ctrl("reset_over_timeout", C_BRANCH);
    tick();
    rst = 1'b1;
    clear_inputs();
    #1;
    chk("rst_state", 32'(hz_if.dbg_state), 32'd0);
    chk("rst_timeout", 32'(hz_if.mem_timeout), 32'd0);
    chk("rst_stall_cnt", hz_if.stall_cycles, 32'd0);
    chk("rst_flush_cnt", 32'(hz_if.flush_events), 32'd0);

    // reset mid-wait abandons the wait
    hz_if.mem_req = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk_ctrl("reset_mid_wait_ctrl", C_FREEZE);
    tick();
    rst = 1'b1;
    clear_inputs();
    #1;
    chk("mid_wait_state", 32'(hz_if.dbg_state), 32'd0);
    chk("mid_wait_stall_cnt", hz_if.stall_cycles, 32'd0);

    // flush counter saturation
    hz_if.ex_branch_taken = 1'b1;
    repeat (65534) tick();
    chk("flush_cnt_fffe", 32'(hz_if.flush_events), 32'h0000_FFFE);
    tick();
    chk("flush_cnt_ffff", 32'(hz_if.flush_events), 32'h0000_FFFF);
    repeat (3) tick();
    chk("flush_cnt_no_wrap", 32'(hz_if.flush_events), 32'h0000_FFFF);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
